// File: rtl/led_breath_seq_pkg.sv
// Shared definitions for the breathing-envelope sequencer: phase encodings and sizing helper.
package led_breath_seq_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE      = 3'd0,
        PH_RAMP_UP   = 3'd1,
        PH_HOLD_HI   = 3'd2,
        PH_RAMP_DOWN = 3'd3,
        PH_HOLD_LO   = 3'd4
    } phase_e;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Divides PWM period ticks down to level-step strobes; clear forces the count back to zero.
module led_tick_div
    import led_breath_seq_pkg::*;
#(
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic step_en_c
);

    localparam int unsigned CNT_W = cnt_width(STEP_PERIODS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_PERIODS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        step_en_c = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                step_en_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_breath_seq.sv
// Breathing-envelope sequencer feeding the LED PWM duty input, paced by the PWM period tick.
// Optional LED_BREATH_GAMMA_EN squares the level (duty = level^2 >> DUTY_W); default is linear.
module led_breath_seq
    import led_breath_seq_pkg::*;
#(
    parameter int unsigned DUTY_W       = 8,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned HOLD_HI_PER  = 64,
    parameter int unsigned HOLD_LO_PER  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              period_tick,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [PHASE_W-1:0] phase,
    output logic              cycle_done
);

    localparam int unsigned HOLD_MAX = (HOLD_HI_PER > HOLD_LO_PER) ? HOLD_HI_PER : HOLD_LO_PER;
    localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_HI_LAST = HOLD_W'(HOLD_HI_PER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LO_LAST = HOLD_W'(HOLD_LO_PER - 1);
    localparam logic [DUTY_W-1:0] MAX_LEVEL    = {DUTY_W{1'b1}};
`ifdef LED_BREATH_GAMMA_EN
    localparam int unsigned PROD_W = 2 * DUTY_W;
`endif

    phase_e            state_q, state_d;
    logic [DUTY_W-1:0] level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              duty_upd_q, duty_upd_d;
    logic              cycle_done_q, cycle_done_d;
    logic              step_clr_c;
    logic              step_en_c;

    // Divider runs only while ramping; an enable drop in RAMP_UP clears it so no step lands.
    assign step_clr_c = !(((state_q == PH_RAMP_UP) && enable) || (state_q == PH_RAMP_DOWN));

    led_tick_div #(
        .STEP_PERIODS(STEP_PERIODS)
    ) u_tick_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (step_clr_c),
        .tick     (period_tick),
        .step_en_c(step_en_c)
    );

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        hold_d       = hold_q;
        cycle_done_d = 1'b0;
        unique case (state_q)
            PH_IDLE: begin
                if (enable) begin
                    state_d = PH_RAMP_UP;
                end
            end
            PH_RAMP_UP: begin
                if (!enable) begin
                    state_d = PH_RAMP_DOWN;
                end else if (step_en_c) begin
                    if (level_q != MAX_LEVEL) begin
                        level_d = level_q + DUTY_W'(1);
                    end
                    if (level_q >= MAX_LEVEL - DUTY_W'(1)) begin
                        state_d = PH_HOLD_HI;
                        hold_d  = '0;
                    end
                end
            end
            PH_HOLD_HI: begin
                if (!enable) begin
                    state_d = PH_RAMP_DOWN;
                    hold_d  = '0;
                end else if (period_tick) begin
                    if (hold_q == HOLD_HI_LAST) begin
                        state_d = PH_RAMP_DOWN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            PH_RAMP_DOWN: begin
                if (step_en_c) begin
                    if (level_q != '0) begin
                        level_d = level_q - DUTY_W'(1);
                    end
                    if (level_q <= DUTY_W'(1)) begin
                        state_d = PH_HOLD_LO;
                        hold_d  = '0;
                    end
                end
            end
            PH_HOLD_LO: begin
                if (period_tick) begin
                    if (hold_q == HOLD_LO_LAST) begin
                        cycle_done_d = 1'b1;
                        hold_d       = '0;
                        state_d      = enable ? PH_RAMP_UP : PH_IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = PH_IDLE;
                level_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Duty mapping; the update strobe follows the mapped value, not the raw level.
    always_comb begin
        duty_d = '0;
`ifdef LED_BREATH_GAMMA_EN
        duty_d = DUTY_W'((PROD_W'(level_d) * PROD_W'(level_d)) >> DUTY_W);
`else
        duty_d = level_d;
`endif
        duty_upd_d = (duty_d != duty_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= PH_IDLE;
            level_q      <= '0;
            hold_q       <= '0;
            duty_q       <= '0;
            duty_upd_q   <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            hold_q       <= hold_d;
            duty_q       <= duty_d;
            duty_upd_q   <= duty_upd_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign duty       = duty_q;
    assign duty_upd   = duty_upd_q;
    assign phase      = state_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_breath_seq.sv
// Scoreboard bench for led_breath_seq (DUTY_W=4, STEP_PERIODS=2, holds of 3, tick every 4 clk).
module tb_led_breath_seq;

    localparam int unsigned DUTY_W = 4;
    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_UP   = 3'd1;
    localparam logic [2:0] P_DOWN = 3'd3;

    typedef struct {
        logic [2:0] ph;
        int         ticks;
    } cd_t;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              period_tick;
    logic [DUTY_W-1:0] duty;
    logic              duty_upd;
    logic [2:0]        phase;
    logic              cycle_done;

    int  checks = 0;
    int  errors = 0;
    int  exp_q[$];
    cd_t cd_q[$];
    int  last_exp = 0;
    int  cd_seen = 0;
    int  upd_cnt = 0;
    int  tick_n = 0;
    bit  tick_on = 1'b0;

    led_breath_seq #(
        .DUTY_W      (DUTY_W),
        .STEP_PERIODS(2),
        .HOLD_HI_PER (3),
        .HOLD_LO_PER (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .period_tick(period_tick),
        .duty       (duty),
        .duty_upd   (duty_upd),
        .phase      (phase),
        .cycle_done (cycle_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock tick every fourth clock, raised just after a rising edge.
    initial begin
        period_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 period_tick = tick_on;
            @(posedge clk);
            #1 period_tick = 1'b0;
        end
    end

    // Ticks the sequencer acts on (state before the edge is not IDLE).
    always @(posedge clk) begin
        if (!rst_n) tick_n = 0;
        else if (period_tick && phase != P_IDLE) tick_n = tick_n + 1;
    end

    function automatic int gam(input int l);
`ifdef LED_BREATH_GAMMA_EN
        return (l * l) >> DUTY_W;
`else
        return l;
`endif
    endfunction

    task automatic push_level(input int l);
        int d;
        d = gam(l);
        if (d != last_exp) begin
            exp_q.push_back(d);
            last_exp = d;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks = checks + 1;
        if (act != expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pops expected duty on each duty_upd, expected phase/tick on each cycle_done.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (duty_upd) begin
                upd_cnt = upd_cnt + 1;
                checks  = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL duty_upd_unexpected: got duty %0d, expected no update", duty);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(duty) != e) begin
                        errors = errors + 1;
                        $display("FAIL duty_value: got %0d, expected %0d", duty, e);
                    end
                end
            end
            if (cycle_done) begin
                cd_seen = cd_seen + 1;
                checks  = checks + 1;
                if (cd_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL cycle_done_unexpected: got pulse, expected none");
                end else begin
                    cd_t c;
                    c = cd_q.pop_front();
                    if (phase != c.ph) begin
                        errors = errors + 1;
                        $display("FAIL cycle_done_phase: got %0d, expected %0d", phase, c.ph);
                    end
                    if (c.ticks >= 0) begin
                        checks = checks + 1;
                        if (tick_n != c.ticks) begin
                            errors = errors + 1;
                            $display("FAIL cycle_done_tick: got tick %0d, expected %0d", tick_n, c.ticks);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_duty(input int v, input int max_cyc, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            #1;
            if (int'(duty) == v) hit = 1'b1;
        end
        chk(name, int'(hit), 1);
    endtask

    task automatic wait_cd(input int target, input int max_cyc, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            #1;
            if (cd_seen >= target) hit = 1'b1;
        end
        chk(name, int'(hit), 1);
    endtask

    task automatic wait_ticks(input int n, input int max_cyc, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < max_cyc && seen < n; i++) begin
            @(posedge clk);
            #2;
            if (period_tick) seen = seen + 1;
        end
        chk(name, seen, n);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        tick_on = 1'b1;

        // 1: reset held with enable and ticks active
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_duty", int'(duty), 0);
        chk("reset_phase", int'(phase), int'(P_IDLE));
        chk("reset_duty_upd", int'(duty_upd), 0);
        chk("reset_cycle_done", int'(cycle_done), 0);

        // 2: one full breath with enable steady
        last_exp = 0;
        for (int l = 1; l <= 15; l++) push_level(l);
        for (int l = 14; l >= 0; l--) push_level(l);
        cd_q.push_back('{ph: P_UP, ticks: 66});
        rst_n = 1'b1;
        wait_cd(1, 400, "breath_cycle_done_timeout");
        tick_on = 1'b0;
        chk("breath_queue_drained", exp_q.size(), 0);

        // 3: ticks stopped, everything frozen
        upd_cnt = 0;
        repeat (100) @(negedge clk);
        chk("frozen_upd_count", upd_cnt, 0);
        chk("frozen_phase", int'(phase), int'(P_UP));
        chk("frozen_duty", int'(duty), 0);

        // 4: enable drops at duty 7 together with the tick that would step to 8
        tick_on = 1'b1;
        for (int l = 1; l <= 7; l++) push_level(l);
        wait_duty(gam(7), 400, "reach7_timeout");
        wait_ticks(2, 40, "drop_tick_timeout");
        enable = 1'b0;
        for (int l = 6; l >= 0; l--) push_level(l);
        cd_q.push_back('{ph: P_IDLE, ticks: -1});
        @(posedge clk);
        @(negedge clk);
        chk("drop_phase", int'(phase), int'(P_DOWN));
        chk("drop_duty", int'(duty), gam(7));
        chk("drop_duty_upd", int'(duty_upd), 0);
        wait_cd(2, 400, "drop_cycle_done_timeout");
        repeat (8) @(negedge clk);
        chk("drop_idle_phase", int'(phase), int'(P_IDLE));
        chk("drop_queue_drained", exp_q.size(), 0);

        // 5: reset in the middle of a ramp
        enable = 1'b1;
        for (int l = 1; l <= 10; l++) push_level(l);
        wait_duty(gam(10), 400, "reach10_timeout");
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_duty", int'(duty), 0);
        chk("midreset_phase", int'(phase), int'(P_IDLE));
        chk("midreset_duty_upd", int'(duty_upd), 0);
        last_exp = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("final_queue_drained", exp_q.size(), 0);
        chk("final_cd_queue_drained", cd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
